// File: rtl/lx32_branch_pkg.sv
// Shared types for the lx32 branch path: comparison ops, resolve-controller states
// and the sequential PC increment.
package lx32_branch_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd2,
        BR_GE  = 3'd3,
        BR_LTU = 3'd4,
        BR_GEU = 3'd5
    } branch_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } brc_state_e;

    localparam int unsigned PC_INC      = 4;
    localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_unit.sv
// Combinational branch comparator: evaluates the condition and picks the
// fall-through or taken target (wraps modulo 2^WIDTH).
module branch_unit
    import lx32_branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_branch,
    input  branch_op_e       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic             taken_c,
    output logic [WIDTH-1:0] target_c
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (op)
            BR_EQ:   cond = (src_a == src_b);
            BR_NE:   cond = (src_a != src_b);
            BR_LT:   cond = ($signed(src_a) <  $signed(src_b));
            BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
            BR_LTU:  cond = (src_a <  src_b);
            BR_GEU:  cond = (src_a >= src_b);
            default: cond = 1'b0;
        endcase
        taken_c  = is_branch && cond;
        target_c = taken_c ? WIDTH'(pc + imm) : WIDTH'(pc + WIDTH'(PC_INC));
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: compares, pulses the outcome, and on a mispredict
// redirects fetch and holds a flush window before accepting the next branch.
module branch_resolve_ctrl
    import lx32_branch_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_pc,
    input  logic [WIDTH-1:0]     req_imm,
    input  logic [WIDTH-1:0]     req_src_a,
    input  logic [WIDTH-1:0]     req_src_b,
    input  branch_op_e           req_op,
    input  logic                 req_pred_taken,
    output logic                 resolve_valid,
    output logic                 resolve_taken,
    output logic                 redir_valid,
    input  logic                 redir_ready,
    output logic [WIDTH-1:0]     redir_pc,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] stat_branches,
    output logic [CNT_WIDTH-1:0] stat_mispredicts
);

    brc_state_e             state, state_next;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   taken;
    logic [WIDTH-1:0]       target;
    logic                   accept;
    logic                   mispredict;

    branch_unit #(.WIDTH(WIDTH)) u_branch_unit (
        .is_branch (req_valid),
        .op        (req_op),
        .src_a     (req_src_a),
        .src_b     (req_src_b),
        .pc        (req_pc),
        .imm       (req_imm),
        .taken_c   (taken),
        .target_c  (target)
    );

    assign req_ready   = (state == IDLE);
    assign redir_valid = (state == REDIRECT);
    assign flush       = (state != IDLE);
    assign accept      = req_valid && req_ready;
    assign mispredict  = accept && (taken != req_pred_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mispredict)  state_next = REDIRECT;
            REDIRECT: if (redir_ready) state_next = FLUSH;
            FLUSH:    if (flush_cnt <= FLUSH_CNT_W'(1)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Flush window: loaded on the redirect handshake, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (state == REDIRECT && redir_ready) begin
            flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
        end else if (state == FLUSH && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_valid <= 1'b0;
            resolve_taken <= 1'b0;
            redir_pc      <= '0;
        end else begin
            resolve_valid <= accept;
            resolve_taken <= accept && taken;
            if (mispredict) redir_pc <= target;
        end
    end

    // Saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accept && stat_branches != '1)
                stat_branches <= stat_branches + CNT_WIDTH'(1);
            if (mispredict && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + CNT_WIDTH'(1);
        end
    end

endmodule
